// File: rtl/mem16_pkg.sv
// mem16_pkg: shared state/phase types and error-counter constants for mem16_ctrl
package mem16_pkg;
  localparam int ERRW = 5;
  localparam logic [ERRW-1:0] ERR_MAX = 5'd31;
  typedef enum logic [2:0] {IDLE, WSET, WSTB, WHLD, RSET, RSMP} state_t;
  typedef enum logic [1:0] {BW0, BR0, BW1, BR1} phase_t;
  function automatic logic inv_phase(input phase_t ph);
    return ph == BW1 || ph == BR1;
  endfunction
endpackage

// File: rtl/mem16_bist_seq.sv
// mem16_bist_seq: march address/phase sequencer, expected-data generator and mismatch counter
module mem16_bist_seq
  import mem16_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 4,
  parameter int BIST_INV = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic            check,
  input  logic [DW-1:0]   pat,
  input  logic [DW-1:0]   y,
  output logic [AW-1:0]   addr_nx,
  output logic [DW-1:0]   exp_nx,
  output logic            last,
  output logic            more,
  output logic [ERRW-1:0] errs,
  output logic            fail,
  output logic [AW-1:0]   fail_ad
);
  logic [AW-1:0] addr;
  logic [DW-1:0] pat_q, pat_nx, exp_d;
  phase_t phase, phase_nx;
  logic mism;
  function automatic logic [DW-1:0] gen(input phase_t ph, input logic [DW-1:0] p, input logic [AW-1:0] a);
    return inv_phase(ph) ? ~(p ^ DW'(a)) : p ^ DW'(a);
  endfunction
  assign last = &addr;
  assign more = BIST_INV != 0 && phase == BR0;
  // Next-state values are exported so the top can register x/ad in lockstep with the counter.
  always_comb begin
    addr_nx = start ? '0 : step ? addr + AW'(1) : addr;
    phase_nx = start ? BW0 : (step && last) ? phase_t'(phase + 2'd1) : phase;
    pat_nx = start ? pat : pat_q;
    exp_nx = gen(phase_nx, pat_nx, addr_nx);
    exp_d = gen(phase, pat_q, addr);
    mism = check && y != exp_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      phase <= BW0;
      pat_q <= '0;
      errs <= '0;
      fail <= 1'b0;
      fail_ad <= '0;
    end else begin
      addr <= addr_nx;
      phase <= phase_nx;
      pat_q <= pat_nx;
      if (start) begin
        errs <= '0;
        fail <= 1'b0;
        fail_ad <= '0;
      end else if (mism) begin
        errs <= errs == ERR_MAX ? errs : errs + ERRW'(1);
        fail <= 1'b1;
        fail_ad <= fail ? fail_ad : addr;
      end
    end
  end
endmodule

// File: rtl/mem16_ctrl.sv
// mem16_ctrl: strobe-timing initiator for a 16x4 async-write memory with host access and march BIST
module mem16_ctrl
  import mem16_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 4,
  parameter int BIST_INV = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic            req_we,
  input  logic [AW-1:0]   req_ad,
  input  logic [DW-1:0]   req_data,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   rd_data,
  input  logic            bist_start,
  input  logic [DW-1:0]   bist_pat,
  output logic            bist_done,
  output logic            bist_fail,
  output logic [ERRW-1:0] bist_errs,
  output logic [AW-1:0]   fail_ad,
  output logic [DW-1:0]   x,
  output logic [AW-1:0]   ad,
  output logic            w,
  output logic            r,
  input  logic [DW-1:0]   y
);
  state_t state, state_nx;
  logic bist, bist_nx, start, step, check, fin, last, more;
  logic [AW-1:0] addr_nx;
  logic [DW-1:0] exp_nx;
  mem16_bist_seq #(.AW(AW), .DW(DW), .BIST_INV(BIST_INV)) u_seq (
    .clk(clk), .rst(rst), .start(start), .step(step), .check(check),
    .pat(bist_pat), .y(y), .addr_nx(addr_nx), .exp_nx(exp_nx), .last(last), .more(more),
    .errs(bist_errs), .fail(bist_fail), .fail_ad(fail_ad)
  );
  // BIST words chain back-to-back through the same write/read states without visiting IDLE.
  always_comb begin
    state_nx = state;
    bist_nx = bist;
    start = 1'b0;
    step = 1'b0;
    check = 1'b0;
    fin = 1'b0;
    case (state)
      IDLE: begin
        if (bist_start) begin
          start = 1'b1;
          bist_nx = 1'b1;
          state_nx = WSET;
        end else if (req) begin
          bist_nx = 1'b0;
          state_nx = req_we ? WSET : RSET;
        end
      end
      WSET: state_nx = WSTB;
      WSTB: state_nx = WHLD;
      WHLD: begin
        step = bist;
        state_nx = !bist ? IDLE : last ? RSET : WSET;
      end
      RSET: state_nx = RSMP;
      RSMP: begin
        step = bist;
        check = bist;
        fin = bist && last && !more;
        state_nx = !bist ? IDLE : !last ? RSET : more ? WSET : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bist <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      w <= 1'b0;
      r <= 1'b0;
      x <= '0;
      ad <= '0;
      rd_data <= '0;
      bist_done <= 1'b0;
    end else begin
      state <= state_nx;
      bist <= bist_nx;
      busy <= state_nx != IDLE;
      done <= !bist && (state == WHLD || state == RSMP);
      w <= state_nx == WSTB;
      r <= state_nx == RSET || state_nx == RSMP;
      ad <= bist_nx ? addr_nx : (state == IDLE && req) ? req_ad : ad;
      x <= bist_nx ? exp_nx : (state == IDLE && req && req_we) ? req_data : x;
      bist_done <= fin | (bist_done & ~start);
      if (!bist && state == RSMP) rd_data <= y;
    end
  end
endmodule

// File: tb/tb_mem16_ctrl.sv
// tb_mem16_ctrl: scoreboard bench with a faultable 16x4 memory model and random host/BIST traffic
module tb_mem16_ctrl;
  logic clk = 0, rst = 1, req = 0, req_we = 0, bist_start = 0;
  logic [3:0] req_ad = 0, req_data = 0, bist_pat = 0;
  logic busy, done, w, r, bist_done, bist_fail;
  logic [3:0] rd_data, fail_ad, x, ad, y;
  logic [4:0] bist_errs;
  logic [3:0] mem[16], sa0[16], sa1[16], rflip[16], ref_mem[16];
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {int kind; logic [3:0] data; int lat; int t0; logic [4:0] errs; logic fail; logic [3:0] fad;} item_t;
  item_t sb[$];
  item_t mit;
  logic [3:0] exp_rd = 0, x_prev = 0, ad_prev = 0;
  logic bd_prev = 0, w_prev = 0;

  mem16_ctrl #(.AW(4), .DW(4), .BIST_INV(1)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_ad(req_ad), .req_data(req_data),
    .busy(busy), .done(done), .rd_data(rd_data), .bist_start(bist_start), .bist_pat(bist_pat),
    .bist_done(bist_done), .bist_fail(bist_fail), .bist_errs(bist_errs), .fail_ad(fail_ad),
    .x(x), .ad(ad), .w(w), .r(r), .y(y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // stuck-at bits are applied on write, read-flip bits on read
  always @(posedge clk) if (w) mem[ad] <= (x & ~sa0[ad]) | sa1[ad];
  assign y = mem[ad] ^ rflip[ad];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) exp_rd = 0;
    else begin
      if (done) begin
        if (sb.size() == 0 || sb[0].kind == 2) chk("unexpected done", 1, 0);
        else begin
          mit = sb.pop_front();
          chk("host latency", cyc - mit.t0, mit.lat);
          if (mit.kind == 1) begin
            chk("rd_data", rd_data, mit.data);
            exp_rd = mit.data;
          end
        end
      end
      if (bist_done && !bd_prev) begin
        if (sb.size() == 0 || sb[0].kind != 2) chk("unexpected bist_done", 1, 0);
        else begin
          mit = sb.pop_front();
          chk("bist latency", cyc - mit.t0, mit.lat);
          chk("bist_errs", bist_errs, mit.errs);
          chk("bist_fail", bist_fail, mit.fail);
          chk("fail_ad", fail_ad, mit.fad);
          chk("rd_data kept over bist", rd_data, exp_rd);
        end
      end
      if (w) begin
        chk("w single cycle", w_prev, 0);
        chk("w r exclusive", r, 0);
        chk("x stable at strobe", x, x_prev);
        chk("ad stable at strobe", ad, ad_prev);
      end
    end
    bd_prev = bist_done;
    w_prev = w;
    x_prev = x;
    ad_prev = ad;
  end

  task automatic wait_idle();
    for (int i = 0; i < 400 && busy; i++) @(negedge clk);
    chk("idle timeout", busy, 0);
  endtask

  task automatic host(input logic we, input logic [3:0] a, input logic [3:0] d);
    item_t it;
    it.kind = we ? 0 : 1;
    it.data = we ? d : ref_mem[a];
    it.lat = we ? 4 : 3;
    it.t0 = cyc;
    it.errs = 0;
    it.fail = 0;
    it.fad = 0;
    if (we) ref_mem[a] = d;
    req = 1; req_we = we; req_ad = a; req_data = d;
    sb.push_back(it);
    @(negedge clk);
    req = 0;
    wait_idle();
  endtask

  task automatic bist_model(input logic [3:0] pat, output item_t it);
    logic [3:0] d, got;
    it.kind = 2; it.lat = 161; it.data = 0; it.t0 = 0;
    it.errs = 0; it.fail = 0; it.fad = 0;
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < 16; a++) begin
        d = pat ^ a[3:0];
        if (p == 1) d = ~d;
        got = ((d & ~sa0[a]) | sa1[a]) ^ rflip[a];
        if (p == 1) ref_mem[a] = (d & ~sa0[a]) | sa1[a];
        if (got != d) begin
          if (it.errs != 31) it.errs++;
          if (!it.fail) begin it.fail = 1; it.fad = a[3:0]; end
        end
      end
  endtask

  task automatic bist(input logic [3:0] pat, input logic with_req);
    item_t it;
    bist_model(pat, it);
    it.t0 = cyc;
    bist_start = 1; bist_pat = pat;
    if (with_req) begin req = 1; req_we = 1; req_ad = 4'($urandom); req_data = 4'($urandom); end
    sb.push_back(it);
    @(negedge clk);
    bist_start = 0; req = 0;
    wait_idle();
  endtask

  initial begin
    item_t it;
    int k;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 0; sa0[i] = 0; sa1[i] = 0; rflip[i] = 0; ref_mem[i] = 0;
    end
    repeat (2) @(negedge clk);
    chk("rst w", w, 0); chk("rst r", r, 0); chk("rst busy", busy, 0); chk("rst done", done, 0);
    chk("rst bist_done", bist_done, 0); chk("rst bist_fail", bist_fail, 0);
    chk("rst bist_errs", bist_errs, 0); chk("rst fail_ad", fail_ad, 0);
    chk("rst rd_data", rd_data, 0); chk("rst x", x, 0); chk("rst ad", ad, 0);
    rst = 0;
    host(1, 3, 4'hA);
    host(0, 3, 0);
    bist(0, 0);
    sa0[5] = 4'b0001;
    bist(0, 0);
    sa0[5] = 0;
    // second request lands while the first write is in flight and must vanish
    it.kind = 0; it.data = 6; it.lat = 4; it.t0 = cyc; it.errs = 0; it.fail = 0; it.fad = 0;
    ref_mem[9] = 6;
    req = 1; req_we = 1; req_ad = 9; req_data = 6;
    sb.push_back(it);
    @(negedge clk);
    req_ad = 10; req_data = 4'hF;
    repeat (2) @(negedge clk);
    req = 0;
    wait_idle();
    host(0, 9, 0);
    host(0, 10, 0);
    bist(4'($urandom), 1);
    bist_start = 1; bist_pat = 4'($urandom);
    @(negedge clk);
    bist_start = 0;
    repeat (49) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("abort w", w, 0); chk("abort r", r, 0); chk("abort busy", busy, 0);
    chk("abort bist_done", bist_done, 0); chk("abort bist_errs", bist_errs, 0);
    rst = 0;
    bist(0, 0);
    repeat (40) host(1'($urandom), 4'($urandom), 4'($urandom));
    repeat (3) begin
      k = $urandom_range(0, 15);
      sa0[k] = 4'($urandom);
      sa1[k] = 4'($urandom) & ~sa0[k];
      bist(4'($urandom), 0);
      sa0[k] = 0; sa1[k] = 0;
    end
    for (int i = 0; i < 16; i++) rflip[i] = 4'b0001;
    bist(4'($urandom), 0);
    for (int i = 0; i < 16; i++) rflip[i] = 0;
    repeat (12) host(1'($urandom), 4'($urandom), 4'($urandom));
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
